// File: rtl/oppm_demodulator.sv
// OPPM receiver: locks frame timing to the first rising edge, checks a slot-0 preamble and
// decodes N_PKT/N_MOD pulse positions MSB first. Define OPPM_SYNC_EN to add a 2-flop input synchronizer.
module oppm_demodulator #(
  parameter int N_MOD  = 2,
  parameter int L      = 4,
  parameter int N_PKT  = 8,
  parameter int PRE_CT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  output logic [N_PKT-1:0] data,
  output logic             valid,
  output logic             error,
  output logic             busy
);

  localparam int NSLOT = 2 ** N_MOD;
  localparam int NSYM  = N_PKT / N_MOD;
  localparam int FMAX  = (PRE_CT > NSYM) ? PRE_CT : NSYM;
  localparam int TW    = (L > 1) ? $clog2(L) : 1;
  localparam int FW    = $clog2(FMAX + 1);

  localparam logic [TW-1:0]    TICK_LAST = TW'(L - 1);
  localparam logic [N_MOD-1:0] SLOT_LAST = N_MOD'(NSLOT - 1);
  localparam logic [FW-1:0]    PRE_LAST  = FW'(PRE_CT - 1);
  localparam logic [FW-1:0]    SYM_LAST  = FW'(NSYM - 1);
  localparam logic [TW-1:0]    TICK_ZERO = {TW{1'b0}};
  localparam logic [N_MOD-1:0] SLOT_ZERO = {N_MOD{1'b0}};
  localparam logic [FW-1:0]    FRM_ZERO  = {FW{1'b0}};
  localparam logic [FW-1:0]    FRM_ONE   = FW'(1);
  localparam logic [N_PKT-1:0] PKT_ZERO  = {N_PKT{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PREAM = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tick_q, tick_d;
  logic [N_MOD-1:0] slot_q, slot_d;
  logic [FW-1:0]    frm_q, frm_d;
  logic [1:0]       hit_cnt_q, hit_cnt_d;
  logic [N_MOD-1:0] hit_slot_q, hit_slot_d;
  logic [N_PKT-1:0] sh_q, sh_d;
  logic             serr_q, serr_d;
  logic             pulse_q, pulse_d;
  logic [N_PKT-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;

  logic             pin_s;
  logic             rise_s;
  logic             tick_end_s;
  logic             frame_end_s;
  logic [1:0]       cur_cnt_s;
  logic [N_MOD-1:0] cur_slot_s;
  logic             good_s;
  logic [N_MOD-1:0] sym_s;
  logic [N_PKT-1:0] sh_next_s;
  logic [TW-1:0]    tick_adv_s;
  logic [N_MOD-1:0] slot_adv_s;

`ifdef OPPM_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], pulse_in};

  // Synchronizer idles high so a line held high through reset is not seen as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pin_s = sync_q[1];
`else
  assign pin_s = pulse_in;
`endif

  // Edge detect, frame timing, per-frame capture and packet assembly.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    slot_d     = slot_q;
    frm_d      = frm_q;
    hit_cnt_d  = hit_cnt_q;
    hit_slot_d = hit_slot_q;
    sh_d       = sh_q;
    serr_d     = serr_q;
    data_d     = data_q;
    error_d    = error_q;
    valid_d    = 1'b0;
    pulse_d    = pin_s;

    rise_s      = pin_s & ~pulse_q;
    tick_end_s  = (tick_q == TICK_LAST);
    frame_end_s = tick_end_s && (slot_q == SLOT_LAST);

    // The current cycle's rise is folded in so a rise on the last tick belongs to its frame.
    if (rise_s) begin
      cur_cnt_s  = (hit_cnt_q == 2'd2) ? 2'd2 : hit_cnt_q + 2'd1;
      cur_slot_s = (hit_cnt_q == 2'd0) ? slot_q : hit_slot_q;
    end else begin
      cur_cnt_s  = hit_cnt_q;
      cur_slot_s = hit_slot_q;
    end
    good_s    = (cur_cnt_s == 2'd1);
    sym_s     = good_s ? cur_slot_s : SLOT_ZERO;
    sh_next_s = (sh_q << N_MOD) | N_PKT'(sym_s);

    if (tick_end_s) begin
      tick_adv_s = TICK_ZERO;
      slot_adv_s = slot_q + 1'b1;
    end else begin
      tick_adv_s = tick_q + 1'b1;
      slot_adv_s = slot_q;
    end

    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d    = PREAM;
          tick_d     = tick_adv_s;
          slot_d     = slot_adv_s;
          frm_d      = FRM_ZERO;
          hit_cnt_d  = 2'd1;
          hit_slot_d = SLOT_ZERO;
        end else begin
          state_d = IDLE;
        end
      end
      PREAM: begin
        tick_d = tick_adv_s;
        slot_d = slot_adv_s;
        if (frame_end_s) begin
          hit_cnt_d  = 2'd0;
          hit_slot_d = SLOT_ZERO;
          if (good_s && (cur_slot_s == SLOT_ZERO)) begin
            if (frm_q == PRE_LAST) begin
              state_d = DATA;
              frm_d   = FRM_ZERO;
              serr_d  = 1'b0;
              sh_d    = PKT_ZERO;
            end else begin
              frm_d = frm_q + FRM_ONE;
            end
          end else begin
            state_d = IDLE;
            frm_d   = FRM_ZERO;
          end
        end else begin
          hit_cnt_d  = cur_cnt_s;
          hit_slot_d = cur_slot_s;
        end
      end
      DATA: begin
        tick_d = tick_adv_s;
        slot_d = slot_adv_s;
        if (frame_end_s) begin
          hit_cnt_d  = 2'd0;
          hit_slot_d = SLOT_ZERO;
          sh_d       = sh_next_s;
          serr_d     = serr_q | ~good_s;
          if (frm_q == SYM_LAST) begin
            data_d  = sh_next_s;
            error_d = serr_q | ~good_s;
            valid_d = 1'b1;
            state_d = IDLE;
            frm_d   = FRM_ZERO;
          end else begin
            frm_d = frm_q + FRM_ONE;
          end
        end else begin
          hit_cnt_d  = cur_cnt_s;
          hit_slot_d = cur_slot_s;
        end
      end
      default: begin
        state_d    = IDLE;
        tick_d     = TICK_ZERO;
        slot_d     = SLOT_ZERO;
        frm_d      = FRM_ZERO;
        hit_cnt_d  = 2'd0;
        hit_slot_d = SLOT_ZERO;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; pulse_q resets high so a stuck-high line cannot lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_q     <= TICK_ZERO;
      slot_q     <= SLOT_ZERO;
      frm_q      <= FRM_ZERO;
      hit_cnt_q  <= 2'd0;
      hit_slot_q <= SLOT_ZERO;
      sh_q       <= PKT_ZERO;
      serr_q     <= 1'b0;
      pulse_q    <= 1'b1;
      data_q     <= PKT_ZERO;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      slot_q     <= slot_d;
      frm_q      <= frm_d;
      hit_cnt_q  <= hit_cnt_d;
      hit_slot_q <= hit_slot_d;
      sh_q       <= sh_d;
      serr_q     <= serr_d;
      pulse_q    <= pulse_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      busy_q     <= busy_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign error = error_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_oppm_demodulator.sv
// Scoreboard bench for oppm_demodulator (N_MOD=2, L=4, N_PKT=8, PRE_CT=3, F=16).
module tb_oppm_demodulator;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         rel;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse_in;
  logic [7:0] data;
  logic       valid;
  logic       error;
  logic       busy;

  exp_t sb_q[$];
  exp_t cur_e;
  int   rise_q[$];
  int   busy_t_q[$];
  logic busy_v_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   base  = 0;

  oppm_demodulator #(.N_MOD(2), .L(4), .N_PKT(8), .PRE_CT(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (pulse_in),
    .data     (data),
    .valid    (valid),
    .error    (error),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output side of the scoreboard: every valid must match the oldest expected packet.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_valid", 32'd1, 32'd0);
      end else begin
        cur_e = sb_q.pop_front();
        check_val("data", 32'(data), 32'(cur_e.data));
        check_val("error", 32'(error), 32'(cur_e.err));
        check_val("valid_time", 32'(cyc - base), 32'(cur_e.rel));
        check_val("busy_at_valid", 32'(busy), 32'd0);
      end
    end
  end

  task automatic add_pkt(input logic [7:0] pkt, input int off);
    logic [1:0] sym;
    rise_q.push_back(0);
    rise_q.push_back(16);
    rise_q.push_back(32);
    for (int i = 0; i < 4; i++) begin
      sym = pkt[7-2*i -: 2];
      rise_q.push_back(48 + 16*i + 4*int'(sym) + off);
    end
  endtask

  task automatic expect_pkt(input logic [7:0] d, input logic e);
    exp_t x;
    x.data = d;
    x.err  = e;
    x.rel  = 112;
    sb_q.push_back(x);
  endtask

  task automatic expect_busy(input int t, input logic v);
    busy_t_q.push_back(t);
    busy_v_q.push_back(v);
  endtask

  // Iteration t drives the input sampled at spec cycle t and sees the outputs of spec cycle t.
  task automatic play(input int n);
    @(negedge clk);
    base = cyc;
    for (int t = 0; t < n; t++) begin
      pulse_in = 1'b0;
      foreach (rise_q[i]) if (rise_q[i] == t) pulse_in = 1'b1;
      foreach (busy_t_q[i]) if (busy_t_q[i] == t) check_val($sformatf("busy_t%0d", t), 32'(busy), 32'(busy_v_q[i]));
      @(negedge clk);
    end
    pulse_in = 1'b0;
    rise_q.delete();
    busy_t_q.delete();
    busy_v_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    pulse_in = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pulse_in = ~pulse_in;
      #1;
      check_val("rst_hold", {28'd0, data[3:0] | data[7:4], valid, error, busy}, 32'd0);
      check_val("rst_data", 32'(data), 32'd0);
    end

    // Line held high across reset release must not lock.
    @(negedge clk);
    pulse_in = 1'b1;
    rst_n    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stuck_high_busy", 32'(busy), 32'd0);
    end
    pulse_in = 1'b0;
    repeat (3) @(negedge clk);
    check_val("after_fall_busy", 32'(busy), 32'd0);

    // Clean packet 0xB4: rises 0,16,32,56,76,84,96.
    add_pkt(8'hB4, 0);
    expect_busy(1, 1'b1);
    expect_busy(111, 1'b1);
    expect_pkt(8'hB4, 1'b0);
    play(120);
    check_val("drain_clean", 32'(sb_q.size()), 32'd0);
    check_val("data_hold", 32'(data), 32'hB4);

    // Missing pulse at 76.
    rise_q = '{0, 16, 32, 56, 84, 96};
    expect_pkt(8'h84, 1'b1);
    play(120);
    check_val("drain_missing", 32'(sb_q.size()), 32'd0);

    // Bad preamble: slot-2 pulse in frame 1 drops the lock silently.
    rise_q = '{0, 24};
    expect_busy(31, 1'b1);
    expect_busy(32, 1'b0);
    expect_busy(39, 1'b0);
    play(40);
    add_pkt(8'h5A, 2);
    expect_pkt(8'h5A, 1'b0);
    play(120);
    check_val("drain_badpre", 32'(sb_q.size()), 32'd0);

    // Duplicate pulse in data frame 0.
    add_pkt(8'hB4, 0);
    rise_q.push_back(58);
    expect_pkt(8'h34, 1'b1);
    play(120);
    check_val("drain_dup", 32'(sb_q.size()), 32'd0);

    // Pulses on the last tick of their slot, including the last tick of a frame.
    add_pkt(8'hC3, 3);
    expect_pkt(8'hC3, 1'b0);
    play(120);
    check_val("drain_lasttick", 32'(sb_q.size()), 32'd0);

    // Reset mid-packet at t=70.
    add_pkt(8'hB4, 0);
    play(70);
    rst_n = 1'b0;
    #1;
    check_val("midrst_data", 32'(data), 32'd0);
    check_val("midrst_flags", {29'd0, valid, error, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("midrst_idle", 32'(busy), 32'd0);
    add_pkt(8'h1B, 1);
    expect_pkt(8'h1B, 1'b0);
    play(120);
    check_val("drain_final", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/oppm_demodulator.md
# oppm_demodulator

Receive-side counterpart of the OPPM transmit path. It consumes the single-bit pulse stream produced by the encoder/modulator and locks frame timing to the first rising edge. It checks a preamble of slot-0 symbols, then decodes N_PKT/N_MOD pulse positions into one N_PKT-bit packet, which it presents with a one-cycle valid strobe and an error flag.

## Interface

Parameters:
- N_MOD, 2, bits per symbol; a frame has 2**N_MOD slots
- L, 4, slot length in clock ticks; frame length F = L*2**N_MOD
- N_PKT, 8, packet bits; must be a multiple of N_MOD
- PRE_CT, 3, preamble frames, pulse in slot 0, including the locking frame; ≥1

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active low
- pulse_in  input  1  received pulse line
- data  output  N_PKT  decoded packet; holds its value until the next valid
- valid  output  1  one-cycle strobe: data/error updated
- error  output  1  packet had a missing or duplicate pulse; qualified by valid
- busy  output  1  high while not IDLE

## Operation

- Edge detect: rise = pulse_in & ~pulse_q. pulse_q is a register that resets to 1, so a line stuck high at reset release is not a rise. Only rising edges matter; pulse width is ignored.
- Counters:
  - tick: 0..L-1, wraps.
  - slot: 0..2**N_MOD-1; increments when tick wraps and wraps at frame end.
  - frame counter: up to max(PRE_CT, N_PKT/N_MOD).
- Per-frame capture: hit_cnt saturates at 2. hit_slot records the slot of the first rise in the frame.
- States:
  - IDLE: a rise defines tick 0 / slot 0 of frame 0. That rise is captured as hit_cnt=1, hit_slot=0. Go to PREAM.
  - PREAM: at frame end (slot=2**N_MOD-1, tick=L-1), evaluate the frame.
    - If hit_cnt==1 and hit_slot==0: increment the preamble count. If the count reaches PRE_CT, go to DATA.
    - Otherwise go to IDLE silently: no valid, no error.
  - DATA: at each frame end, shift into the packet.
    - hit_cnt==1: shift in hit_slot.
    - Otherwise: shift in 0 and set the sticky error.
    - After N_PKT/N_MOD frames: load the shift register into data, load the sticky error into error, pulse valid, go to IDLE.
- Bit order: the first data symbol lands in data[N_PKT-1 -: N_MOD], i.e. MSB first.
- Per-frame capture (hit_cnt, hit_slot) clears at every frame end. The sticky error clears on entry to DATA.

## Timing

- Reset values: data=0, valid=0, error=0, busy=0; state IDLE; all counters 0; pulse_q=1. Reset mid-packet aborts immediately and discards partial data.
- Edge latency (OPPM_SYNC_EN undefined): a rise on pulse_in at cycle c is seen in cycle c.
- Frame-end evaluation: a rise on the last tick of a frame belongs to that frame.
- Packet latency: valid is registered and asserts in the cycle after the final tick of the last data frame. data and error change in that same cycle.
- PREAM→DATA transition: the frame after the PRE_CT-th preamble frame end is data frame 0.
- busy: busy=0 in the cycle valid is high. A rise in that cycle begins a new lock.
- Frame count: total frames per packet = PRE_CT + N_PKT/N_MOD.
- Saturation: hit_cnt saturating at 2 means more than 2 rises per frame behaves as 2.

## Configuration

- OPPM_SYNC_EN defined: pulse_in passes through a 2-flop synchronizer, which resets to 1, before edge detection. Edge detect and all downstream events shift 2 cycles later; decoded values are unchanged.
- OPPM_SYNC_EN undefined: pulse_in feeds edge detection directly and must be synchronous to clk.

## Test plan

All scenarios use N_MOD=2, L=4, N_PKT=8, PRE_CT=3 (F=16), macro undefined, lock rise at t=0.
- Reset: hold rst_n low, toggle pulse_in -> data=0, valid=0, error=0, busy=0 throughout.
- Clean packet 0xB4:
  - Stimulus: rises at t=0, 16, 32 (preamble), then 56, 76, 84, 96 (symbols 2, 3, 1, 0).
  - Required: valid high exactly at t=112, data=0xB4, error=0, busy=0 at t=112.
- Missing pulse: as 0xB4 but omit the rise at 76 -> valid at t=112, data=0x84, error=1.
- Bad preamble: rises at 0 and 24 (slot 2 of frame 1) -> busy falls at t=32, no valid. A fresh clean packet starting later decodes correctly.
- Duplicate: as 0xB4 plus an extra rise at 58 -> error=1, symbol 0 inserted for frame 3, data=0x34.
- Reset mid-packet: assert rst_n at t=70 -> all outputs 0 immediately. After release, a clean 0x1B packet gives valid with data=0x1B, error=0.
